gate_pipe: RTL and testbench
============================

GATE_PIPE -- requirements
Module: gate_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width in bits, legal 1..64.
REQ-002 Parameter STAGES, default 2: register stages from input to output, legal 1..4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  input beat present.
REQ-006 in_ready  output  1  block accepts input beat this cycle.
REQ-007 in_op  input  3  operation code (encodings in REQ-012).
REQ-008 in_a  input  WIDTH  operand A.
REQ-009 in_b  input  WIDTH  operand B; ignored by unary ops.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 out_y  output  WIDTH  result; op codes: 0 NOT a, 1 BUF a, 2 AND, 3 OR, 4 XOR, 5 NAND, 6 NOR, 7 XNOR (bitwise).
REQ-013 out_op  output  3  op code that produced out_y.
REQ-014 op_count  output  16  number of result beats accepted downstream.

Function
REQ-015 Input transfer occurs on a rising edge with in_valid=1 and in_ready=1; output transfer with out_valid=1 and out_ready=1.
REQ-016 Result computed combinationally from in_a/in_b/in_op and captured into stage 0 on input transfer.
REQ-017 Each stage holds valid, op, y; stage k loads from stage k-1 when stage k is empty or its content moves on this cycle.
REQ-018 Per-stage ready = !valid_k || ready_{k+1}; last stage ready = out_ready; in_ready = stage 0 ready (combinational, no bubble).
REQ-019 Latency: result visible on out_valid exactly STAGES cycles after input transfer when pipeline does not stall.
REQ-020 Throughput: one beat per cycle sustained while out_ready=1.
REQ-021 out_ready=0 with all stages full: in_ready=0, every stage holds its data unchanged; no beat lost or duplicated.
REQ-022 Order preserved: results leave in input-transfer order.
REQ-023 out_y, out_op hold stable while out_valid=1 and out_ready=0.
REQ-024 op_count increments by 1 per output transfer; wraps 0xFFFF -> 0x0000.
REQ-025 Simultaneous input and output transfer on a full pipeline permitted; occupancy unchanged.
REQ-026 Data fields of invalid stages are don't-care; out_y undefined-by-contract when out_valid=0 (reset value still 0).

Reset
REQ-027 rst=1 asynchronously clears all stage valid bits, y and op fields to 0, op_count to 0.
REQ-028 During reset out_valid=0, out_y=0, out_op=0, op_count=0, in_ready=0.
REQ-029 Reset mid-operation discards all in-flight beats; first cycle after release in_ready=1, out_valid=0.

Structure
REQ-030 Package gate_pkg holds op-code constants (OP_NOT..OP_XNOR) and the 3-bit op type.
REQ-031 One sub-module gate_pipe_stage (one valid/op/y register with ready logic), instantiated STAGES times by generate.
REQ-032 Op evaluation is a function in gate_pkg, not a separate module.

Verification
REQ-033 WIDTH=8, STAGES=2, out_ready=1; send op0 a=0x0F -> out_y=0xF0, out_op=0, out_valid exactly 2 cycles later.
REQ-034 Back-to-back ops 2..7 with a=0xCC, b=0xAA -> out_y sequence 0x88,0xEE,0x66,0x77,0x11,0x99 on consecutive cycles, op_count=6.
REQ-035 Fill pipeline with out_ready=0 -> in_ready=0 after 2 accepted beats; hold 5 cycles, out_y stable; release -> both beats delivered in order.
REQ-036 Preload op_count to 0xFFFE via 3 further transfers after 65533 -> sequence 0xFFFE,0xFFFF,0x0000.
REQ-037 Assert rst asynchronously with 2 beats in flight -> out_valid drops same instant, op_count=0; no stale beat after release.
REQ-038 Random valid/ready toggling, STAGES=1 and 4, WIDTH=1 and 64 -> scoreboard matches golden model, no loss or duplication.

Source files
------------

// File: rtl/gate_pkg.sv
// Op codes, op type and the bitwise op evaluator shared by the
// gate pipeline and its stages.
package gate_pkg;

   typedef logic [2:0] op_t;

   localparam op_t OP_NOT  = 3'd0;
   localparam op_t OP_BUF  = 3'd1;
   localparam op_t OP_AND  = 3'd2;
   localparam op_t OP_OR   = 3'd3;
   localparam op_t OP_XOR  = 3'd4;
   localparam op_t OP_NAND = 3'd5;
   localparam op_t OP_NOR  = 3'd6;
   localparam op_t OP_XNOR = 3'd7;

   localparam int MAX_WIDTH = 64;

   // Evaluated at full width; callers truncate to their own WIDTH.
   function automatic logic [MAX_WIDTH-1:0] gate_eval(
      op_t                  op,
      logic [MAX_WIDTH-1:0] a,
      logic [MAX_WIDTH-1:0] b
   );
      logic [MAX_WIDTH-1:0] y;
      y = '0;
      unique case (op)
         OP_NOT:  y = ~a;
         OP_BUF:  y = a;
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_XNOR: y = ~(a ^ b);
      endcase
      return y;
   endfunction

endpackage

// File: rtl/gate_pipe_if.sv
// Input and output valid/ready channels of the gate pipeline.
// The slave modport is the pipeline side, master the environment side.
interface gate_pipe_if #(
   parameter int WIDTH = 8
) ();
   import gate_pkg::*;

   logic             in_valid;
   logic             in_ready;
   op_t              in_op;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_y;
   op_t              out_op;

   modport master (
      output in_valid, in_op, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_y, out_op
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, out_ready,
      output in_ready, out_valid, out_y, out_op
   );

endinterface

// File: rtl/gate_pipe_stage.sv
// One pipeline register slot (valid, op, y) that loads from upstream
// whenever it is empty or its content moves on this cycle.
module gate_pipe_stage
   import gate_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_valid,
   input  op_t              up_op,
   input  logic [WIDTH-1:0] up_y,
   input  logic             down_ready,
   output logic             valid,
   output op_t              op,
   output logic [WIDTH-1:0] y
);

   logic ready;

   assign ready = !valid || down_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         op    <= '0;
         y     <= '0;
      end else if (ready) begin
         valid <= up_valid;
         if (up_valid) begin
            op <= up_op;
            y  <= up_y;
         end
      end
   end

endmodule

// File: rtl/gate_pipe.sv
// Elastic bitwise-gate pipeline: result computed on entry, then carried
// through STAGES valid/ready register slots; counts delivered beats.
module gate_pipe
   import gate_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   gate_pipe_if.slave  bus,
   output logic [15:0] op_count
);

   logic [WIDTH-1:0]  y_in;
   logic [STAGES-1:0] vs;
   op_t               os [STAGES];
   logic [WIDTH-1:0]  ys [STAGES];
   logic [STAGES:0]   rdy;

   assign y_in = WIDTH'(gate_eval(bus.in_op,
                                  MAX_WIDTH'(bus.in_a),
                                  MAX_WIDTH'(bus.in_b)));

   // rdy[k] is the ready of stage k, rdy[STAGES] the sink; the chain
   // is built from the valid bits only so it never loops through itself.
   always_comb begin
      rdy         = '0;
      rdy[STAGES] = bus.out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         rdy[k] = !vs[k] || rdy[k+1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             uv;
      op_t              uo;
      logic [WIDTH-1:0] uy;

      if (k == 0) begin : g_head
         assign uv = bus.in_valid;
         assign uo = bus.in_op;
         assign uy = y_in;
      end else begin : g_body
         assign uv = vs[k-1];
         assign uo = os[k-1];
         assign uy = ys[k-1];
      end

      gate_pipe_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk        (clk),
         .rst        (rst),
         .up_valid   (uv),
         .up_op      (uo),
         .up_y       (uy),
         .down_ready (rdy[k+1]),
         .valid      (vs[k]),
         .op         (os[k]),
         .y          (ys[k])
      );
   end

   assign bus.in_ready  = !rst && rdy[0];
   assign bus.out_valid = vs[STAGES-1];
   assign bus.out_y     = ys[STAGES-1];
   assign bus.out_op    = os[STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_count <= '0;
      end else if (vs[STAGES-1] && bus.out_ready) begin
         op_count <= op_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_gate_pipe.sv
// Bench for gate_pipe: directed vector table and corner sequences on an
// 8-bit/2-stage instance, random traffic on 1-bit/1-stage and 64-bit/4-stage.
module tb_gate_pipe;
   import gate_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   gate_pipe_if #(.WIDTH(8))  b8 ();
   gate_pipe_if #(.WIDTH(1))  b1 ();
   gate_pipe_if #(.WIDTH(64)) b64 ();

   logic [15:0] cnt8;
   logic [15:0] cnt1;
   logic [15:0] cnt64;

   gate_pipe #(.WIDTH(8), .STAGES(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (b8),
      .op_count (cnt8)
   );

   gate_pipe #(.WIDTH(1), .STAGES(1)) u_w1 (
      .clk      (clk),
      .rst      (rst),
      .bus      (b1),
      .op_count (cnt1)
   );

   gate_pipe #(.WIDTH(64), .STAGES(4)) u_w64 (
      .clk      (clk),
      .rst      (rst),
      .bus      (b64),
      .op_count (cnt64)
   );

   int nvec = 0;
   int nerr = 0;

   typedef struct {
      op_t        op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] y;
   } vec_t;

   typedef struct {
      op_t         op;
      logic [63:0] y;
   } exp_t;

   vec_t        tbl [11];
   logic [3:0]  tt [8];
   logic [7:0]  seq [6];
   exp_t        q1 [$];
   exp_t        q64 [$];
   bit          hold [2];
   logic [63:0] hy [2];
   op_t         ho [2];
   int          ntx [2];

   task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Reference: per-bit truth table lookup indexed by {a_i, b_i}.
   function automatic logic [63:0] ref_gate(op_t op, logic [63:0] a,
                                            logic [63:0] b, int w);
      logic [63:0] r;
      logic [3:0]  t;
      r = '0;
      t = tt[op];
      for (int i = 0; i < w; i++) begin
         r[i] = t[{a[i], b[i]}];
      end
      return r;
   endfunction

   task automatic idle();
      b8.in_valid  = 1'b0;  b8.in_op  = '0;  b8.in_a  = '0;  b8.in_b  = '0;
      b8.out_ready = 1'b1;
      b1.in_valid  = 1'b0;  b1.in_op  = '0;  b1.in_a  = '0;  b1.in_b  = '0;
      b1.out_ready = 1'b1;
      b64.in_valid = 1'b0;  b64.in_op = '0;  b64.in_a = '0;  b64.in_b = '0;
      b64.out_ready = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send8(op_t op, logic [7:0] a, logic [7:0] b);
      b8.in_valid = 1'b1;
      b8.in_op    = op;
      b8.in_a     = a;
      b8.in_b     = b;
   endtask

   task automatic mstep(int k, int stages, int w, bit iv, bit ir, op_t iop,
                        logic [63:0] a, logic [63:0] b, bit ov, bit ordy,
                        logic [63:0] y, op_t oo);
      int   sz;
      exp_t e;
      sz = (k == 0) ? q1.size() : q64.size();
      chk($sformatf("rnd%0d_in_ready", k), 64'(ir),
          64'((sz < stages) || ordy));
      if (sz == 0) chk($sformatf("rnd%0d_valid_empty", k), 64'(ov), 64'd0);
      if (hold[k]) begin
         chk($sformatf("rnd%0d_hold_valid", k), 64'(ov), 64'd1);
         chk($sformatf("rnd%0d_hold_y", k), y, hy[k]);
         chk($sformatf("rnd%0d_hold_op", k), 64'(oo), 64'(ho[k]));
      end
      if (ov && ordy && sz > 0) begin
         e = (k == 0) ? q1.pop_front() : q64.pop_front();
         chk($sformatf("rnd%0d_y", k), y, e.y);
         chk($sformatf("rnd%0d_op", k), 64'(oo), 64'(e.op));
         ntx[k]++;
      end
      hold[k] = ov && !ordy;
      hy[k]   = y;
      ho[k]   = oo;
      if (iv && ir) begin
         e.op = iop;
         e.y  = ref_gate(iop, a, b, w);
         if (k == 0) q1.push_back(e);
         else q64.push_back(e);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int          n;
      bit          iv [2];
      bit          ordy [2];
      op_t         op [2];
      logic [63:0] a [2];
      logic [63:0] b [2];
      int          ph;

      tt[0] = 4'b0011;  tt[1] = 4'b1100;  tt[2] = 4'b1000;  tt[3] = 4'b1110;
      tt[4] = 4'b0110;  tt[5] = 4'b0111;  tt[6] = 4'b0001;  tt[7] = 4'b1001;

      tbl[0]  = '{OP_NOT,  8'h0F, 8'h00, 8'hF0};
      tbl[1]  = '{OP_BUF,  8'h5A, 8'hFF, 8'h5A};
      tbl[2]  = '{OP_AND,  8'hCC, 8'hAA, 8'h88};
      tbl[3]  = '{OP_OR,   8'hCC, 8'hAA, 8'hEE};
      tbl[4]  = '{OP_XOR,  8'hCC, 8'hAA, 8'h66};
      tbl[5]  = '{OP_NAND, 8'hCC, 8'hAA, 8'h77};
      tbl[6]  = '{OP_NOR,  8'hCC, 8'hAA, 8'h11};
      tbl[7]  = '{OP_XNOR, 8'hCC, 8'hAA, 8'h99};
      tbl[8]  = '{OP_NOT,  8'h00, 8'h55, 8'hFF};
      tbl[9]  = '{OP_NAND, 8'hFF, 8'hFF, 8'h00};
      tbl[10] = '{OP_XNOR, 8'h3C, 8'hC3, 8'h00};

      seq[0] = 8'h88;  seq[1] = 8'hEE;  seq[2] = 8'h66;
      seq[3] = 8'h77;  seq[4] = 8'h11;  seq[5] = 8'h99;

      idle();
      #1 rst = 1'b1;
      b8.in_valid = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_out_valid", 64'(b8.out_valid), 64'd0);
      chk("rst_out_y", 64'(b8.out_y), 64'd0);
      chk("rst_out_op", 64'(b8.out_op), 64'd0);
      chk("rst_op_count", 64'(cnt8), 64'd0);
      chk("rst_in_ready", 64'(b8.in_ready), 64'd0);
      @(negedge clk);
      idle();
      rst = 1'b0;

      // Single beats: latency of exactly two cycles, table of op results.
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         send8(tbl[i].op, tbl[i].a, tbl[i].b);
         #1 chk("tbl_in_ready", 64'(b8.in_ready), 64'd1);
         @(negedge clk);
         b8.in_valid = 1'b0;
         #1 chk("tbl_early_valid", 64'(b8.out_valid), 64'd0);
         @(negedge clk);
         #1;
         chk($sformatf("tbl%0d_valid", i), 64'(b8.out_valid), 64'd1);
         chk($sformatf("tbl%0d_y", i), 64'(b8.out_y), 64'(tbl[i].y));
         chk($sformatf("tbl%0d_op", i), 64'(b8.out_op), 64'(tbl[i].op));
      end
      @(negedge clk);
      #1 chk("tbl_op_count", 64'(cnt8), 64'd11);

      // Back-to-back ops 2..7.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i < 6) send8(op_t'(i + 2), 8'hCC, 8'hAA);
         else b8.in_valid = 1'b0;
         #1;
         if (i < 6) chk("b2b_in_ready", 64'(b8.in_ready), 64'd1);
         if (i >= 2 && i < 8) begin
            chk("b2b_valid", 64'(b8.out_valid), 64'd1);
            chk($sformatf("b2b_y%0d", i - 2), 64'(b8.out_y), 64'(seq[i-2]));
         end
      end
      chk("b2b_op_count", 64'(cnt8), 64'd6);

      // Full pipeline with the sink stalled.
      do_reset();
      b8.out_ready = 1'b0;
      @(negedge clk);
      send8(OP_AND, 8'hF0, 8'h3C);
      #1 chk("stall_rdy1", 64'(b8.in_ready), 64'd1);
      @(negedge clk);
      send8(OP_OR, 8'hF0, 8'h3C);
      #1 chk("stall_rdy2", 64'(b8.in_ready), 64'd1);
      @(negedge clk);
      send8(OP_XOR, 8'hF0, 8'h3C);
      #1 chk("stall_full", 64'(b8.in_ready), 64'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         chk("stall_in_ready", 64'(b8.in_ready), 64'd0);
         chk("stall_valid", 64'(b8.out_valid), 64'd1);
         chk("stall_y", 64'(b8.out_y), 64'h30);
         chk("stall_op", 64'(b8.out_op), 64'(OP_AND));
      end
      @(negedge clk);
      b8.out_ready = 1'b1;
      #1;
      chk("rel_in_ready", 64'(b8.in_ready), 64'd1);
      chk("rel_y0", 64'(b8.out_y), 64'h30);
      @(negedge clk);
      b8.in_valid = 1'b0;
      #1;
      chk("rel_y1", 64'(b8.out_y), 64'hFC);
      chk("rel_op1", 64'(b8.out_op), 64'(OP_OR));
      @(negedge clk);
      #1;
      chk("rel_y2", 64'(b8.out_y), 64'hCC);
      chk("rel_op2", 64'(b8.out_op), 64'(OP_XOR));
      @(negedge clk);
      #1;
      chk("rel_empty", 64'(b8.out_valid), 64'd0);
      chk("rel_op_count", 64'(cnt8), 64'd3);

      // Asynchronous reset with two beats in flight.
      do_reset();
      @(negedge clk);
      send8(OP_BUF, 8'h11, 8'h00);
      @(negedge clk);
      b8.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      b8.out_ready = 1'b0;
      send8(OP_AND, 8'hFF, 8'h0F);
      @(negedge clk);
      send8(OP_OR, 8'hFF, 8'h0F);
      @(negedge clk);
      b8.in_valid = 1'b0;
      #1;
      chk("ar_pre_valid", 64'(b8.out_valid), 64'd1);
      chk("ar_pre_count", 64'(cnt8), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("ar_valid", 64'(b8.out_valid), 64'd0);
      chk("ar_count", 64'(cnt8), 64'd0);
      chk("ar_y", 64'(b8.out_y), 64'd0);
      chk("ar_in_ready", 64'(b8.in_ready), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      b8.out_ready = 1'b1;
      #1;
      chk("ar_rel_ready", 64'(b8.in_ready), 64'd1);
      chk("ar_rel_valid", 64'(b8.out_valid), 64'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1 chk("ar_stale", 64'(b8.out_valid), 64'd0);
      end

      // op_count wrap with continuous streaming.
      @(negedge clk);
      send8(OP_BUF, 8'hA5, 8'h00);
      n = 0;
      while (n < 70000) begin
         @(negedge clk);
         #1;
         if (cnt8 == 16'hFFFE) break;
         n++;
      end
      chk("wrap_fffe", 64'(cnt8), 64'hFFFE);
      @(negedge clk);
      #1 chk("wrap_ffff", 64'(cnt8), 64'hFFFF);
      @(negedge clk);
      #1 chk("wrap_0000", 64'(cnt8), 64'h0000);
      b8.in_valid = 1'b0;

      // Random traffic on the narrow and wide instances.
      do_reset();
      for (int k = 0; k < 2; k++) begin
         hold[k] = 1'b0;
         ntx[k]  = 0;
      end
      for (int c = 0; c < 3020; c++) begin
         @(negedge clk);
         ph = (c / 400) % 3;
         for (int k = 0; k < 2; k++) begin
            if (c >= 3000) begin
               iv[k]   = 1'b0;
               ordy[k] = 1'b1;
            end else if (ph == 2) begin
               iv[k]   = 1'b1;
               ordy[k] = 1'b1;
            end else begin
               iv[k]   = $urandom_range(0, 3) != 0;
               ordy[k] = (ph == 0) ? ($urandom_range(0, 3) != 0)
                                   : ($urandom_range(0, 3) == 0);
            end
            op[k] = 3'($urandom_range(0, 7));
            a[k]  = {$urandom, $urandom};
            b[k]  = {$urandom, $urandom};
         end
         b1.in_valid   = iv[0];
         b1.in_op      = op[0];
         b1.in_a       = a[0][0];
         b1.in_b       = b[0][0];
         b1.out_ready  = ordy[0];
         b64.in_valid  = iv[1];
         b64.in_op     = op[1];
         b64.in_a      = a[1];
         b64.in_b      = b[1];
         b64.out_ready = ordy[1];
         #1;
         mstep(0, 1, 1, iv[0], b1.in_ready, op[0], a[0], b[0],
               b1.out_valid, ordy[0], 64'(b1.out_y), b1.out_op);
         mstep(1, 4, 64, iv[1], b64.in_ready, op[1], a[1], b[1],
               b64.out_valid, ordy[1], b64.out_y, b64.out_op);
      end
      chk("rnd0_drained", 64'(q1.size()), 64'd0);
      chk("rnd1_drained", 64'(q64.size()), 64'd0);
      chk("rnd0_out_idle", 64'(b1.out_valid), 64'd0);
      chk("rnd1_out_idle", 64'(b64.out_valid), 64'd0);
      chk("rnd0_op_count", 64'(cnt1), 64'(ntx[0] % 65536));
      chk("rnd1_op_count", 64'(cnt64), 64'(ntx[1] % 65536));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
